// File: rtl/display_text_writer.sv
// Writer side of the display text path: shadow text buffer fed by a symbol/command
// stream, committed to `numbers` on frame_sync when TEXT_WRITER_VSYNC_COMMIT_EN is defined.
module display_text_writer #(
  parameter int MAX_INPUT = 384,
  parameter int COLS = 80,
  localparam int SLOTS = MAX_INPUT / 4,
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_valid,
  input  logic [1:0]           sym_op,
  input  logic [3:0]           sym_code,
  output logic                 sym_ready,
  input  logic                 frame_sync,
  output logic [MAX_INPUT-1:0] numbers,
  output logic [CW-1:0]        cursor,
  output logic                 full,
  output logic                 overflow
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_INPUT-1:0] shadow_q, shadow_d;
  logic [CW-1:0]        cur_q, cur_d;
  logic [CW-1:0]        clr_q, clr_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;

  logic                 xfer;
  logic                 op_wr, op_bs, op_clr, op_nl;
  logic [31:0]          nl_w;
  logic [CW-1:0]        nl_cur;
  logic [CW-1:0]        bs_cur;

  assign sym_ready = (state_q == IDLE);
  assign xfer      = sym_valid && sym_ready;

  assign op_wr  = xfer && (sym_op == 2'b00);
  assign op_bs  = xfer && (sym_op == 2'b01);
  assign op_clr = xfer && (sym_op == 2'b10);
  assign op_nl  = xfer && (sym_op == 2'b11);

  // Start of the next row, clamped to the end of the buffer.
  assign nl_w   = (32'(cur_q) / 32'(COLS) + 32'd1) * 32'(COLS);
  assign nl_cur = (nl_w > 32'(SLOTS)) ? CW'(SLOTS) : CW'(nl_w);
  assign bs_cur = cur_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cur_d    = cur_q;
    clr_d    = clr_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          op_wr: begin
            if (!full_q) begin
              shadow_d[{cur_q, 2'b00} +: 4] = sym_code;
              cur_d = cur_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          op_bs: begin
            if (cur_q != '0) begin
              cur_d = bs_cur;
              shadow_d[{bs_cur, 2'b00} +: 4] = 4'hf;
            end
          end
          op_clr: begin
            state_d = CLEAR;
            clr_d   = '0;
          end
          op_nl: begin
            cur_d = nl_cur;
          end
          default: ;
        endcase
      end
      CLEAR: begin
        shadow_d[{clr_q, 2'b00} +: 4] = 4'hf;
        clr_d = clr_q + 1'b1;
        if (clr_q == CW'(SLOTS - 1)) begin
          state_d = IDLE;
          cur_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = (cur_d == CW'(SLOTS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= {MAX_INPUT{1'b1}};
      cur_q    <= '0;
      clr_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cur_q    <= cur_d;
      clr_q    <= clr_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef TEXT_WRITER_VSYNC_COMMIT_EN
  logic [MAX_INPUT-1:0] numbers_q, numbers_d;
  logic                 pend_q, pend_d;

  // A sync seen mid-clear is deferred so the display only shows the finished clear.
  always_comb begin
    numbers_d = numbers_q;
    pend_d    = pend_q;
    if (state_q == IDLE) begin
      if (frame_sync || pend_q) begin
        numbers_d = shadow_q;
        pend_d    = 1'b0;
      end
    end else if (frame_sync) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numbers_q <= {MAX_INPUT{1'b1}};
      pend_q    <= 1'b0;
    end else begin
      numbers_q <= numbers_d;
      pend_q    <= pend_d;
    end
  end

  assign numbers = numbers_q;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
  assign numbers = shadow_q;
`endif

  assign cursor   = cur_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_text_writer.sv
// Self-checking bench for display_text_writer: directed table, corner sequences,
// and random traffic against a slot-array reference model.
module tb_display_text_writer;

  localparam int MI = 384;
  localparam int CL = 80;
  localparam int NS = MI / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sym_valid = 1'b0;
  logic [1:0]    sym_op = 2'b00;
  logic [3:0]    sym_code = 4'h0;
  logic          sym_ready;
  logic          frame_sync = 1'b0;
  logic [MI-1:0] numbers;
  logic [6:0]    cursor;
  logic          full;
  logic          overflow;

  display_text_writer #(.MAX_INPUT(MI), .COLS(CL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sym_valid(sym_valid),
    .sym_op(sym_op),
    .sym_code(sym_code),
    .sym_ready(sym_ready),
    .frame_sync(frame_sync),
    .numbers(numbers),
    .cursor(cursor),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: text as an array of slots
  logic [3:0] m_sh[NS];
  logic [3:0] m_dp[NS];
  int         m_cur;
  int         m_busy;
  bit         m_ovf;
  bit         m_pend;

  task automatic chk(input string nm, input logic [MI-1:0] a, input logic [MI-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_sh[i] = 4'hf;
      m_dp[i] = 4'hf;
    end
    m_cur = 0; m_busy = 0; m_ovf = 0; m_pend = 0;
  endtask

  function automatic logic [MI-1:0] m_numbers();
    logic [MI-1:0] r;
    for (int i = 0; i < NS; i++) begin
`ifdef TEXT_WRITER_VSYNC_COMMIT_EN
      r[4*i +: 4] = m_dp[i];
`else
      r[4*i +: 4] = m_sh[i];
`endif
    end
    return r;
  endfunction

  task automatic m_edge(input bit v, input logic [1:0] op, input logic [3:0] cd, input bit fs);
    int nl;
    if (m_busy > 0) begin
      if (fs) m_pend = 1;
      m_sh[NS - m_busy] = 4'hf;
      m_busy--;
      if (m_busy == 0) begin
        m_cur = 0;
        m_ovf = 0;
      end
    end else begin
      if (fs || m_pend) begin
        for (int i = 0; i < NS; i++) m_dp[i] = m_sh[i];
        m_pend = 0;
      end
      if (v) begin
        case (op)
          2'b00: if (m_cur < NS) begin m_sh[m_cur] = cd; m_cur++; end else m_ovf = 1;
          2'b01: if (m_cur > 0) begin m_cur--; m_sh[m_cur] = 4'hf; end
          2'b10: m_busy = NS;
          default: begin
            nl = (m_cur / CL + 1) * CL;
            m_cur = (nl > NS) ? NS : nl;
          end
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".numbers"}, numbers, m_numbers());
    chk({tag, ".cursor"}, MI'(cursor), MI'(m_cur));
    chk({tag, ".full"}, MI'(full), MI'(m_cur == NS));
    chk({tag, ".overflow"}, MI'(overflow), MI'(m_ovf));
    chk({tag, ".ready"}, MI'(sym_ready), MI'(m_busy == 0));
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [3:0] cd, input bit fs,
                      input string tag);
    sym_valid = v; sym_op = op; sym_code = cd; frame_sync = fs;
    m_edge(v, op, cd, fs);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [3:0] cd;
    bit         fs;
    int         cur;
    logic [15:0] lo_c;
    logic [15:0] lo_d;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    logic [15:0] lo_e;
    bit v;
    logic [1:0] op;
    int r;

    tbl[0] = '{1, 2'b00, 4'h1, 0, 1,  16'hffff, 16'hfff1};
    tbl[1] = '{1, 2'b00, 4'ha, 0, 2,  16'hffff, 16'hffa1};
    tbl[2] = '{1, 2'b00, 4'h2, 0, 3,  16'hffff, 16'hf2a1};
    tbl[3] = '{1, 2'b00, 4'he, 0, 4,  16'hffff, 16'he2a1};
    tbl[4] = '{0, 2'b00, 4'h0, 1, 4,  16'he2a1, 16'he2a1};
    tbl[5] = '{1, 2'b11, 4'h0, 0, 80, 16'he2a1, 16'he2a1};
    tbl[6] = '{1, 2'b00, 4'h7, 1, 81, 16'he2a1, 16'he2a1};
    tbl[7] = '{0, 2'b00, 4'h0, 1, 81, 16'he2a1, 16'he2a1};

    m_reset();
    #12;
    check_all("reset");
    chk("reset.all_f", numbers, {MI{1'b1}});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].cd, tbl[i].fs, $sformatf("tbl%0d", i));
`ifdef TEXT_WRITER_VSYNC_COMMIT_EN
      lo_e = tbl[i].lo_c;
`else
      lo_e = tbl[i].lo_d;
`endif
      chk($sformatf("tbl%0d.cur", i), MI'(cursor), MI'(tbl[i].cur));
      chk($sformatf("tbl%0d.lo16", i), MI'(numbers[15:0]), MI'(lo_e));
    end
    chk("nl.slot80", MI'(numbers[323:320]), MI'(4'h7));
    chk("nl.slots4_79", MI'(numbers[319:16]), MI'({304{1'b1}}));

    // fill to full, overflow, backspace from full
    step(1, 2'b10, 0, 0, "clr0");
    while (!sym_ready) step(0, 0, 0, 0, "clr0w");
    for (int i = 0; i < NS; i++) step(1, 2'b00, 4'($urandom_range(0, 14)), 0, "fill");
    chk("fill.full", MI'(full), MI'(1));
    step(1, 2'b00, 4'h3, 0, "ovf");
    chk("ovf.flag", MI'(overflow), MI'(1));
    chk("ovf.cur", MI'(cursor), MI'(96));
    step(1, 2'b01, 0, 0, "bs_full");
    chk("bs_full.cur", MI'(cursor), MI'(95));
    chk("bs_full.full", MI'(full), MI'(0));
    chk("bs_full.ovf", MI'(overflow), MI'(1));
    step(0, 0, 0, 1, "bs_commit");
    chk("bs_full.slot95", MI'(numbers[383:380]), MI'(4'hf));

    // clear with a mid-clear sync: busy count and deferred commit
    step(1, 2'b10, 0, 0, "clr1");
    n = 0;
    while (!sym_ready && n < 200) begin
      step(0, 0, 0, n == 40, "clr1w");
      n++;
    end
    chk("clr1.busy_cycles", MI'(n), MI'(96));
    step(0, 0, 0, 0, "clr1_idle");
    chk("clr1.all_f", numbers, {MI{1'b1}});
    chk("clr1.cur", MI'(cursor), MI'(0));
    chk("clr1.ovf", MI'(overflow), MI'(0));

    step(1, 2'b01, 0, 0, "bs0");
    chk("bs0.cur", MI'(cursor), MI'(0));

    // write coincident with sync
    step(1, 2'b00, 4'h5, 1, "wsync");
`ifdef TEXT_WRITER_VSYNC_COMMIT_EN
    chk("wsync.slot0", MI'(numbers[3:0]), MI'(4'hf));
`else
    chk("wsync.slot0", MI'(numbers[3:0]), MI'(4'h5));
`endif
    step(0, 0, 0, 1, "wsync2");
    chk("wsync2.slot0", MI'(numbers[3:0]), MI'(4'h5));

    // reset mid-clear
    step(1, 2'b10, 0, 0, "clr2");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, "clr2w");
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      op = (r < 70) ? 2'b00 : (r < 85) ? 2'b01 : (r < 87) ? 2'b10 : 2'b11;
      step(v, op, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_text_writer.md
# display_text_writer

Writer side of the calculator's text display path. It accepts a stream of 4-bit symbol codes and edit commands over a valid/ready handshake and keeps them in a shadow text buffer. At each frame boundary it commits the shadow buffer to the packed `numbers` bus that the VGA picture generator reads, so the display never tears mid-frame. The block sits between the calculator core/keypad logic and the picture generator.

## Interface
Parameters:
- `MAX_INPUT`, 384, width of `numbers` in bits; SLOTS = MAX_INPUT/4 character slots (96 at default).
- `COLS`, 80, characters per display row (640 px / 8 px glyph).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sym_valid`  in  1  request valid.
- `sym_op`  in  2  command: 00 write symbol, 01 backspace, 10 clear, 11 newline.
- `sym_code`  in  4  symbol for op 00: 0–9 digits, a `+`, b `-`, c `*`, d `/`, e `=`, f blank.
- `sym_ready`  out  1  block can accept a request.
- `frame_sync`  in  1  frame-boundary pulse (vsync edge), synchronous to `clk`.
- `numbers`  out  MAX_INPUT  committed buffer; slot i occupies `numbers[4i+3:4i]`, and slot index = row*COLS + col.
- `cursor`  out  $clog2(SLOTS+1)  next slot to write (0..SLOTS).
- `full`  out  1  `cursor == SLOTS`.
- `overflow`  out  1  sticky; set when a write is dropped because the buffer is full.

## Operation
- A transfer occurs on a rising edge where `sym_valid && sym_ready`.
- `sym_ready` = (state == IDLE). Inputs are ignored when no transfer occurs.
- State machine:
  - IDLE handles all ops. An accepted clear goes to CLEAR.
  - CLEAR writes f to one slot per cycle, index 0 to SLOTS-1.
  - After the last slot: `cursor` = 0, `overflow` = 0, return to IDLE.
- Write:
  - If not full: shadow[cursor] = `sym_code` and `cursor` increments.
  - If full: the transfer is still accepted, the data is dropped, and `overflow` = 1.
- Backspace:
  - If `cursor` > 0: `cursor` decrements, and shadow[new cursor] = f. This works from full too (96 → 95, `full` drops).
  - If `cursor` = 0: no-op.
- Newline:
  - `cursor` = min((cursor/COLS + 1)*COLS, SLOTS). For example 4 → 80, 85 → 96.
  - No slot contents change. Newline when already full is a no-op.
- Commit:
  - On a cycle in IDLE with `frame_sync` high, `numbers` loads the shadow contents as they were before that edge.
  - A write accepted in the same cycle appears at the next commit.
- Commit during CLEAR: `frame_sync` sets a pending flag. The commit happens on the first IDLE cycle and always shows the fully cleared buffer.
- `full` and `overflow` are registered outputs, consistent with `cursor` in the same cycle.

## Timing
- Reset (asynchronous): shadow and `numbers` all f (`{MAX_INPUT{1'b1}}`), `cursor` 0, `full` 0, `overflow` 0, `sym_ready` 1, state IDLE, commit-pending flag 0.
- Write, backspace and newline take effect at the accepting edge; `cursor`, `full` and `overflow` update at that same edge.
- `numbers` updates at the `frame_sync` edge, so the write-to-display latency is up to the next `frame_sync`.
- Clear: `sym_ready` is 0 for exactly SLOTS cycles after the accepting edge, then returns to 1.
- Reset asserted mid-clear aborts it and the reset values apply. The buffer is all f either way.
- `frame_sync` held high commits on every IDLE cycle.

## Configuration
- `TEXT_WRITER_VSYNC_COMMIT_EN`
  - Defined: `numbers` updates only on a commit, as described above.
  - Undefined: `numbers` is the shadow buffer itself, updated at the accepting edge (or per cleared slot during CLEAR). `frame_sync` and the pending flag are unused.

## Test plan
- Reset → `numbers` = all ones, `cursor` = 0, `sym_ready` = 1, `full` = 0, `overflow` = 0.
- Write 1, a, 2, e (`numbers[15:0]` stays 16'hffff), then pulse `frame_sync` → `numbers[15:0]` = 16'he2a1, `cursor` = 4.
- Write 1, a, 2, e (cursor 4), newline → `cursor` = 80; write 7 and commit → `numbers[323:320]` = 4'h7, slots 4–79 still f.
- 96 writes → `full` = 1. A 97th write → accepted, dropped, `overflow` = 1. Backspace → `cursor` = 95, slot 95 = f after commit, `full` = 0, `overflow` still 1.
- Clear with `frame_sync` pulsed mid-clear → `sym_ready` low exactly 96 cycles. The commit fires on the first IDLE cycle with `numbers` all f, `cursor` = 0, `overflow` = 0.
- Backspace at `cursor` 0 → no change.
- Write 5 in the same cycle as `frame_sync` → slot unchanged in `numbers` until the next `frame_sync`. With the macro undefined, it is visible at the accepting edge.
